// File: rtl/mc_ctrl_fsm.sv
// Multicycle RISC-V control sequencer: fetch/data memory handshakes, stall, illegal-opcode trap, retire counter.
// Optional memory wait timeout enabled by defining CTRL_MEM_TIMEOUT_EN.
module mc_ctrl_fsm #(
  parameter int unsigned INST_TYPE_W    = 4,
  parameter int unsigned RETIRE_W       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   CLK,
  input  logic                   RES_N,
  input  logic [6:0]             opcode,
  input  logic                   memReady,
  input  logic                   stall,
  input  logic                   trapClear,
  output logic                   memReq,
  output logic                   instWrite,
  output logic                   isFetch,
  output logic                   regWrite,
  output logic                   aluSrcA,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   memToReg,
  output logic                   isJump,
  output logic                   isBranch,
  output logic [1:0]             aluSrcB,
  output logic [INST_TYPE_W-1:0] instType,
  output logic                   retire,
  output logic [RETIRE_W-1:0]    retireCount,
  output logic                   trap,
  output logic [1:0]             trapCause
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd5;

  localparam logic [3:0] C_ILLEGAL = 4'd0;
  localparam logic [3:0] C_R       = 4'd1;
  localparam logic [3:0] C_I       = 4'd2;
  localparam logic [3:0] C_JALR    = 4'd3;
  localparam logic [3:0] C_LOAD    = 4'd4;
  localparam logic [3:0] C_STORE   = 4'd5;
  localparam logic [3:0] C_BRANCH  = 4'd6;
  localparam logic [3:0] C_JAL     = 4'd7;
  localparam logic [3:0] C_LUI     = 4'd8;
  localparam logic [3:0] C_AUIPC   = 4'd9;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'd2;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'd3;

  logic [2:0]          state_d, state_q;
  logic [1:0]          trapCause_d, trapCause_q;
  logic [RETIRE_W-1:0] retireCount_q;
  logic [3:0]          cls;
  logic                mem_timeout;

  always_comb begin
    case (opcode)
      7'b0110011: cls = C_R;
      7'b0010011: cls = C_I;
      7'b1100111: cls = C_JALR;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b1100011: cls = C_BRANCH;
      7'b1101111: cls = C_JAL;
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      default:    cls = C_ILLEGAL;
    endcase
  end

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [7:0] wait_d, wait_q;

  assign mem_timeout = !memReady && (wait_q == 8'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every entry into a memory-waiting state, including TRAP -> FETCH.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM))
      wait_d = '0;
    else if (memReq && !memReady)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  logic unused_timeout;
  assign mem_timeout    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    trapCause_d = trapCause_q;
    memReq      = 1'b0;
    instWrite   = 1'b0;
    isFetch     = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    isJump      = 1'b0;
    isBranch    = 1'b0;
    aluSrcB     = 2'b00;
    instType    = '0;
    retire      = 1'b0;
    trap        = 1'b0;

    case (state_q)
      S_FETCH: begin
        memReq  = 1'b1;
        isFetch = 1'b1;
        memRead = 1'b1;
        if (memReady) begin
          instWrite = 1'b1;
          state_d   = S_DECODE;
        end else if (mem_timeout) begin
          state_d     = S_TRAP;
          trapCause_d = CAUSE_FETCH_TO;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          if (cls == C_ILLEGAL) begin
            state_d     = S_TRAP;
            trapCause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = S_EXECUTE;
          end
        end
      end
      S_EXECUTE: begin
        instType = INST_TYPE_W'(cls);
        case (cls)
          C_I, C_LOAD, C_STORE, C_LUI: aluSrcB = 2'b01;
          C_JALR, C_JAL: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            isJump  = 1'b1;
          end
          C_AUIPC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b01;
          end
          C_BRANCH: isBranch = 1'b1;
          default:  aluSrcB  = 2'b00;
        endcase
        if (!stall) begin
          if (cls == C_BRANCH) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else if (cls == C_LOAD || cls == C_STORE) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_MEM: begin
        memReq   = 1'b1;
        memRead  = (cls == C_LOAD);
        memWrite = (cls == C_STORE);
        if (memReady) begin
          if (cls == C_LOAD) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (mem_timeout) begin
          state_d     = S_TRAP;
          trapCause_d = CAUSE_DATA_TO;
        end
      end
      S_WB: begin
        regWrite = !stall;
        memToReg = (cls == C_LOAD);
        if (!stall) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trapClear) begin
          state_d     = S_FETCH;
          trapCause_d = CAUSE_NONE;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs must drop the instant reset asserts, not at the next clock.
    if (!RES_N) begin
      memReq    = 1'b0;
      instWrite = 1'b0;
      isFetch   = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 1'b0;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      memToReg  = 1'b0;
      isJump    = 1'b0;
      isBranch  = 1'b0;
      aluSrcB   = 2'b00;
      instType  = '0;
      retire    = 1'b0;
      trap      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state_q       <= S_FETCH;
      trapCause_q   <= CAUSE_NONE;
      retireCount_q <= '0;
    end else begin
      state_q     <= state_d;
      trapCause_q <= trapCause_d;
      if (retire) retireCount_q <= retireCount_q + RETIRE_W'(1);
    end
  end

  assign retireCount = retireCount_q;
  assign trapCause   = trapCause_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction phase model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;
  localparam int unsigned TO = 4;
`ifdef CTRL_MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_JALR = 7'b1100111,
                         OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BAD = 7'b1111111;

  logic CLK = 1'b0, RES_N = 1'b1;
  logic [6:0] opcode = '0;
  logic memReady = 1'b0, stall = 1'b0, trapClear = 1'b0;
  logic memReq, instWrite, isFetch, regWrite, aluSrcA, memRead, memWrite, memToReg, isJump, isBranch;
  logic [1:0] aluSrcB;
  logic [3:0] instType;
  logic retire, trap;
  logic [31:0] retireCount;
  logic [1:0] trapCause;

  int n_cmp = 0, n_bad = 0;
  bit check_en = 1'b0;

  mc_ctrl_fsm #(.INST_TYPE_W(4), .RETIRE_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RES_N(RES_N), .opcode(opcode), .memReady(memReady), .stall(stall),
    .trapClear(trapClear), .memReq(memReq), .instWrite(instWrite), .isFetch(isFetch),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .isJump(isJump), .isBranch(isBranch), .aluSrcB(aluSrcB),
    .instType(instType), .retire(retire), .retireCount(retireCount), .trap(trap),
    .trapCause(trapCause)
  );

  always #5 CLK = ~CLK;

  // Model: which step of the instruction's life we are in, plus retired count and trap cause.
  typedef enum int {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} phase_t;
  phase_t      ph = P_FETCH;
  int unsigned waited = 0;
  logic [31:0] m_cnt = '0;
  logic [1:0]  m_cause = '0;

  function automatic int unsigned cls_of(input logic [6:0] op);
    case (op)
      OP_R: return 1;     OP_I: return 2;   OP_JALR: return 3;
      OP_LD: return 4;    OP_ST: return 5;  OP_BR: return 6;
      OP_JAL: return 7;   OP_LUI: return 8; OP_AUIPC: return 9;
      default: return 0;
    endcase
  endfunction

  always @(posedge CLK or negedge RES_N) begin : model
    int unsigned c;
    if (!RES_N) begin
      ph = P_FETCH; waited = 0; m_cnt = '0; m_cause = 2'd0;
    end else begin
      c = cls_of(opcode);
      case (ph)
        P_FETCH:
          if (memReady) ph = P_DECODE;
          else if (TO_EN && waited == TO - 1) begin ph = P_TRAP; m_cause = 2'd2; end
          else waited++;
        P_DECODE:
          if (!stall) begin
            if (c == 0) begin ph = P_TRAP; m_cause = 2'd1; end
            else ph = P_EXEC;
          end
        P_EXEC:
          if (!stall) begin
            if (c == 6) begin ph = P_FETCH; waited = 0; m_cnt = m_cnt + 1; end
            else if (c == 4 || c == 5) begin ph = P_MEM; waited = 0; end
            else ph = P_WB;
          end
        P_MEM:
          if (memReady) begin
            if (c == 4) ph = P_WB;
            else begin ph = P_FETCH; waited = 0; m_cnt = m_cnt + 1; end
          end else if (TO_EN && waited == TO - 1) begin ph = P_TRAP; m_cause = 2'd3; end
          else waited++;
        P_WB:
          if (!stall) begin ph = P_FETCH; waited = 0; m_cnt = m_cnt + 1; end
        P_TRAP:
          if (trapClear) begin ph = P_FETCH; waited = 0; m_cause = 2'd0; end
        default: ph = P_FETCH;
      endcase
    end
  end

  always @(negedge CLK) begin : cmp
    int unsigned c;
    logic [19:0] a, e;
    logic eReq, eIW, eIF, eRW, eSA, eMR, eMW, eM2R, eJ, eB, eRet, eTrap;
    logic [1:0] eSB;
    logic [3:0] eIT;
    if (check_en) begin
      c = cls_of(opcode);
      {eReq, eIW, eIF, eRW, eSA, eMR, eMW, eM2R, eJ, eB, eRet, eTrap} = '0;
      eSB = 2'd0; eIT = 4'd0;
      if (RES_N) begin
        case (ph)
          P_FETCH: begin eReq = 1; eIF = 1; eMR = 1; eIW = memReady; end
          P_EXEC: begin
            eIT = 4'(c);
            eSB = (c == 2 || c == 4 || c == 5 || c == 8 || c == 9) ? 2'd1 :
                  (c == 3 || c == 7) ? 2'd2 : 2'd0;
            eSA = (c == 3 || c == 7 || c == 9);
            eJ = (c == 3 || c == 7);
            eB = (c == 6);
            eRet = (c == 6) && !stall;
          end
          P_MEM: begin eReq = 1; eMR = (c == 4); eMW = (c == 5); eRet = memReady && (c != 4); end
          P_WB: begin eRW = !stall; eM2R = (c == 4); eRet = !stall; end
          P_TRAP: eTrap = 1;
          default: eTrap = 0;
        endcase
      end
      e = {eReq, eIW, eIF, eRW, eSA, eMR, eMW, eM2R, eJ, eB, eSB, eIT, eRet, eTrap, m_cause};
      a = {memReq, instWrite, isFetch, regWrite, aluSrcA, memRead, memWrite, memToReg,
           isJump, isBranch, aluSrcB, instType, retire, trap, trapCause};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL ctrl t=%0t phase=%0d got %05h expected %05h", $time, ph, a, e);
      end
      n_cmp++;
      if (retireCount !== m_cnt) begin
        n_bad++;
        $display("FAIL retireCount t=%0t got %0d expected %0d", $time, retireCount, m_cnt);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  logic [6:0] ops [11] = '{OP_R, OP_I, OP_JALR, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI, OP_AUIPC, OP_BAD, 7'b0000000};

  initial begin
    #1 RES_N = 1'b0;
    check_en = 1'b1;
    #2;
    lit("reset_outputs", {memReq, isFetch, memRead, trap, retire}, 0);
    lit("reset_count", retireCount, 0);
    @(posedge CLK); go();
    RES_N = 1'b1;

    // R-type, immediate memReady: retire in cycle 4
    opcode = OP_R; memReady = 1; #3 lit("r_fetch_instWrite", instWrite, 1); go();
    memReady = 0; #3 lit("r_decode_memReq", memReq, 0); go();
    #3 lit("r_exec_instType", instType, 1); lit("r_exec_regWrite", regWrite, 0); go();
    #3 lit("r_wb", {regWrite, retire}, 2'b11); go();
    #3 lit("r_count", retireCount, 1); lit("r_back_fetch", isFetch, 1);

    // LOAD, memReady delayed 3 cycles in MEM_ACCESS: 8 cycles total
    opcode = OP_LD; memReady = 1; go();
    memReady = 0; go();
    #3 lit("ld_exec_aluSrcB", aluSrcB, 1); go();
    repeat (3) begin #3 lit("ld_mem_wait", {memReq, memRead, memWrite}, 3'b110); go(); end
    memReady = 1; #3 lit("ld_mem_done", {memReq, memRead, retire}, 3'b110); go();
    memReady = 0; #3 lit("ld_wb", {regWrite, memToReg, retire}, 3'b111); go();
    #3 lit("ld_count", retireCount, 2);

    // Illegal opcode: TRAP in cycle 3, cleared by trapClear
    opcode = OP_BAD; memReady = 1; go();
    memReady = 0; go();
    #3 lit("ill_trap", {trap, trapCause, retire}, 4'b1010); lit("ill_count", retireCount, 2); go();
    #3 lit("ill_trap_hold", trap, 1); trapClear = 1; go();
    trapClear = 0; #3 lit("ill_cleared", {trap, trapCause, isFetch}, 4'b0001);

    // I-calc with stall in DECODE (1 cycle) and WRITEBACK (2 cycles)
    opcode = OP_I; memReady = 1; go();
    memReady = 0; stall = 1; go();
    stall = 0; go();
    #3 lit("i_exec", {instType, aluSrcB}, 6'b001001); go();
    stall = 1; #3 lit("i_wb_stall1", {regWrite, retire}, 2'b00); go();
    #3 lit("i_wb_stall2", {regWrite, retire}, 2'b00); go();
    stall = 0; #3 lit("i_wb_release", {regWrite, retire}, 2'b11); go();
    #3 lit("i_count", retireCount, 3);

    // Mixed traffic, model-checked every cycle; opcode only changes while fetching
    for (int i = 0; i < 400; i++) begin
      if (ph == P_FETCH) opcode = ops[$urandom_range(0, 10)];
      memReady  = ($urandom_range(0, 2) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      trapClear = (ph == P_TRAP) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      go();
    end
    memReady = 0; stall = 0; trapClear = 0;

`ifdef CTRL_MEM_TIMEOUT_EN
    RES_N = 0; go(); RES_N = 1;
    opcode = OP_R;
    repeat (4) begin #3 lit("to_fetch_wait", isFetch, 1); go(); end
    #3 lit("to_trap", {trap, trapCause}, 3'b110); trapClear = 1; go();
    trapClear = 0;
    repeat (3) go();
    memReady = 1; #3 lit("to_ready_wins", instWrite, 1); go();
    memReady = 0; #3 lit("to_no_trap", {trap, isFetch}, 2'b00); go();
`endif

    // Asynchronous reset during STORE MEM_ACCESS
    opcode = OP_ST;
    RES_N = 0; go(); RES_N = 1;
    memReady = 1; go();
    memReady = 0; go(); go();
    #3 lit("st_mem_write", {memReq, memWrite}, 2'b11);
    RES_N = 0;
    #1 lit("st_async_drop", {memReq, memWrite}, 2'b00); lit("st_async_count", retireCount, 0);
    go();
    RES_N = 1;
    #3 lit("st_after_reset", {isFetch, trap}, 2'b10); lit("st_after_count", retireCount, 0);
    go(); go();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
